blink_period_meter: RTL and testbench

//  Receive end of the LED blink interface: samples a toggling blink line (e.g. an LEDG output) and

---
 rtl/blink_pkg.sv | 7 +
 rtl/blink_sync_edge.sv | 12 +
 rtl/blink_period_meter.sv | 86 ++++++++
 tb/tb_blink_period_meter.sv | 105 ++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// blink_pkg: shared state encoding and default parameters for the blink interface
package blink_pkg;
    localparam int CNT_W_DEF = 27;
    localparam int TIMEOUT_DEF = 100000000;
    localparam int FAST_THRESH_DEF = 1000;
    typedef enum logic [1:0] {IDLE, MEASURE, STALLED} state_t;
endpackage

// File: rtl/blink_sync_edge.sv
// blink_sync_edge: 2-FF synchronizer plus history FF; edge_p pulses on either polarity (ports clk, rst, din -> edge_p)
module blink_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic edge_p
);
    logic [2:0] sh_q, sh_d;
    always_comb sh_d = {sh_q[1:0], din};
    always_ff @(posedge clk) sh_q <= rst ? 3'b000 : sh_d;
    assign edge_p = sh_q[2] ^ sh_q[1];
endmodule

// File: rtl/blink_period_meter.sv
// blink_period_meter: measures blink half-period (CLOCK_50, reset, blink_in -> half_period, valid, is_fast, stalled); BLINK_AVG4_EN reports a 4-interval average
module blink_period_meter
    import blink_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int FAST_THRESH = FAST_THRESH_DEF
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             blink_in,
    output logic [CNT_W-1:0] half_period,
    output logic             valid,
    output logic             is_fast,
    output logic             stalled
);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] FT = CNT_W'(FAST_THRESH);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, half_q, half_d, rep_val;
    logic valid_q, valid_d, fast_q, fast_d, edge_p, rep, rep_ok, clr;
    blink_sync_edge u_sync (
        .clk(CLOCK_50),
        .rst(reset),
        .din(blink_in),
        .edge_p(edge_p)
    );
    assign rep = edge_p && state_q == MEASURE;
    assign clr = edge_p && state_q != MEASURE;
`ifdef BLINK_AVG4_EN
    logic [CNT_W-1:0] h0_q, h1_q, h2_q, h0_d, h1_d, h2_d;
    logic [1:0] n_q, n_d;
    logic [CNT_W+1:0] sum;
    always_comb begin
        sum = {2'b00, cnt_q} + {2'b00, h0_q} + {2'b00, h1_q} + {2'b00, h2_q};
        rep_val = sum[CNT_W+1:2];
        rep_ok = rep && n_q == 2'd3;
        n_d = clr ? 2'd0 : (rep && n_q != 2'd3) ? n_q + 2'd1 : n_q;
        h0_d = clr ? '0 : rep ? cnt_q : h0_q;
        h1_d = clr ? '0 : rep ? h0_q : h1_q;
        h2_d = clr ? '0 : rep ? h1_q : h2_q;
    end
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            n_q <= 2'd0;
            h0_q <= '0;
            h1_q <= '0;
            h2_q <= '0;
        end else begin
            n_q <= n_d;
            h0_q <= h0_d;
            h1_q <= h1_d;
            h2_q <= h2_d;
        end
    end
`else
    assign rep_val = cnt_q;
    assign rep_ok = rep;
`endif
    always_comb begin
        state_d = edge_p ? MEASURE : (state_q == MEASURE && cnt_q == TMO) ? STALLED : state_q;
        cnt_d = edge_p ? CNT_W'(1) : (cnt_q == TMO) ? cnt_q : cnt_q + 1'b1;
        valid_d = rep_ok;
        half_d = rep_ok ? rep_val : half_q;
        fast_d = rep_ok ? rep_val < FT : fast_q;
    end
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            half_q <= '0;
            valid_q <= 1'b0;
            fast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            half_q <= half_d;
            valid_q <= valid_d;
            fast_q <= fast_d;
        end
    end
    assign half_period = half_q;
    assign valid = valid_q;
    assign is_fast = fast_q;
    assign stalled = state_q == STALLED;
endmodule

// File: tb/tb_blink_period_meter.sv
// tb_blink_period_meter: directed toggles with a scoreboard of expected reports checked by a monitor
module tb_blink_period_meter;
    localparam int TMO = 2000;
    localparam int FT = 1000;
    logic CLOCK_50 = 1'b0;
    logic reset = 1'b1;
    logic blink_in = 1'b0;
    logic [26:0] half_period;
    logic valid, is_fast, stalled;
    int n_chk = 0;
    int n_fail = 0;
    int sb[$];
    always #10 CLOCK_50 = ~CLOCK_50;
    blink_period_meter #(
        .CNT_W(27),
        .TIMEOUT(TMO),
        .FAST_THRESH(FT)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .blink_in(blink_in),
        .half_period(half_period),
        .valid(valid),
        .is_fast(is_fast),
        .stalled(stalled)
    );
    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask
    task automatic tog(input int n, input int e);
        idle(n);
        blink_in = ~blink_in;
        if (e >= 0) sb.push_back(e);
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_half_period"}, half_period, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_is_fast"}, is_fast, 0);
        chk({tag, "_stalled"}, stalled, 0);
    endtask
    initial fork
        forever begin
            @(negedge CLOCK_50);
            if (!reset && valid) begin
                int e;
                e = sb.size() != 0 ? sb.pop_front() : -1;
                chk("report_half_period", half_period, e);
                chk("report_is_fast", is_fast, longint'(e >= 0 && e < FT));
            end
        end
        begin
            idle(3);
            chk_zero("reset");
            reset = 1'b0;
`ifdef BLINK_AVG4_EN
            tog(20, -1);
            tog(100, -1);
            tog(200, -1);
            tog(300, -1);
            tog(401, 250);
            tog(250, 287);
            tog(1500, 612);
            idle(10);
            chk("avg_stalled", stalled, 0);
`else
            tog(20, -1);
            repeat (4) tog(250, 250);
            repeat (3) tog(1500, 1500);
            tog(700, 700);
            tog(250, 250);
            idle(1990);
            chk("stall_early", stalled, 0);
            idle(110);
            chk("stall_set", stalled, 1);
            idle(400);
            chk("stall_held", stalled, 1);
            tog(0, -1);
            idle(6);
            chk("stall_cleared", stalled, 0);
            tog(294, 300);
            idle(100);
            reset = 1'b1;
            @(negedge CLOCK_50);
            reset = 1'b0;
            chk_zero("mid_reset");
            tog(50, -1);
            tog(400, 400);
            tog(TMO, TMO);
            idle(10);
            chk("timeout_edge_stalled", stalled, 0);
`endif
            idle(10);
            chk("scoreboard_drained", sb.size(), 0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    join
endmodule
